// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: transaction direction and target FSM states.
package i2c_target_pkg;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_transaction_t;

  typedef enum logic [2:0] {
    S_T_IDLE,
    S_T_ADDR,
    S_T_ACK_ADDR,
    S_T_WR_DATA,
    S_T_ACK_WR,
    S_T_RD_DATA,
    S_T_ACK_RD,
    S_T_IGNORE
  } i2c_target_state_t;

  localparam logic [2:0] BIT_MSB = 3'd7;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one asynchronous I2C line, plus registered edge flags.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address: WRITE bytes out on a ready/valid stream,
// READ bytes served from a 1-deep input buffer. Oversampled, no clock stretching.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS   = 7'h3C,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  output logic             i_ready,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output i2c_transaction_t mode,
  output logic             busy
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_line  (scl),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_line  (sda),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  i2c_target_state_t r_state;
  i2c_transaction_t  r_mode;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_sda_low;
  logic              r_busy;
  logic              r_ack_drv;
  logic              r_o_valid;
  logic [7:0]        r_o_data;
  logic [7:0]        r_buf;
  logic              r_buf_full;

  logic       w_start;
  logic       w_stop;
  logic       w_load;
  logic [7:0] w_load_byte;
  logic [7:0] w_shift_in;

  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  assign w_shift_in = {r_shift[6:0], w_sda_lvl};

  // A byte arriving in the same clk as a load bypasses the buffer.
  assign w_load_byte = r_buf_full ? r_buf : (i_valid ? i_data : IDLE_BYTE);
  assign w_load = !w_start && !w_stop && w_scl_fall && r_ack_drv &&
                  ((r_state == S_T_ACK_ADDR && r_mode == I2C_READ) ||
                   (r_state == S_T_ACK_RD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_T_IDLE;
      r_mode     <= I2C_WRITE;
      r_bit_cnt  <= BIT_MSB;
      r_shift    <= '0;
      r_sda_low  <= 1'b0;
      r_busy     <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_o_valid <= 1'b0;
      if (w_load) begin
        r_buf_full <= 1'b0;
      end else if (i_valid && !r_buf_full) begin
        r_buf      <= i_data;
        r_buf_full <= 1'b1;
      end

      if (w_start) begin
        r_state   <= S_T_ADDR;
        r_bit_cnt <= BIT_MSB;
        r_shift   <= '0;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
        r_ack_drv <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_T_IDLE;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
        r_ack_drv <= 1'b0;
      end else begin
        case (r_state)
          S_T_IDLE: ;
          S_T_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_shift_in;
              if (r_bit_cnt == 3'd0) begin
                r_bit_cnt <= BIT_MSB;
                if (w_shift_in[7:1] == ADDRESS) begin
                  r_mode    <= i2c_transaction_t'(w_shift_in[0]);
                  r_ack_drv <= 1'b0;
                  r_state   <= S_T_ACK_ADDR;
                end else begin
                  r_state <= S_T_IGNORE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end
          end
          S_T_ACK_ADDR, S_T_ACK_WR: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_low <= 1'b1;
                r_busy    <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_bit_cnt <= BIT_MSB;
                if (w_load) begin
                  r_shift   <= {w_load_byte[6:0], 1'b0};
                  r_sda_low <= ~w_load_byte[7];
                  r_state   <= S_T_RD_DATA;
                end else begin
                  r_sda_low <= 1'b0;
                  r_state   <= S_T_WR_DATA;
                end
              end
            end
          end
          S_T_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= w_shift_in;
              if (r_bit_cnt == 3'd0) begin
                r_bit_cnt <= BIT_MSB;
                if (o_ready) begin
                  r_o_data  <= w_shift_in;
                  r_o_valid <= 1'b1;
                  r_ack_drv <= 1'b0;
                  r_state   <= S_T_ACK_WR;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_T_IGNORE;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end
          end
          S_T_RD_DATA: begin
            // r_shift[7] always holds the next bit to present; MSB already on the bus.
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_sda_low <= 1'b0;
                r_ack_drv <= 1'b0;
                r_state   <= S_T_ACK_RD;
              end else begin
                r_sda_low <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end
          end
          S_T_ACK_RD: begin
            if (w_scl_rise) begin
              if (!w_sda_lvl) begin
                r_ack_drv <= 1'b1;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_T_IGNORE;
              end
            end else if (w_load) begin
              r_ack_drv <= 1'b0;
              r_bit_cnt <= BIT_MSB;
              r_shift   <= {w_load_byte[6:0], 1'b0};
              r_sda_low <= ~w_load_byte[7];
              r_state   <= S_T_RD_DATA;
            end
          end
          S_T_IGNORE: r_sda_low <= 1'b0;
          default:    r_state <= S_T_IDLE;
        endcase
      end
    end
  end

  assign sda     = r_sda_low ? 1'b0 : 1'bz;
  assign i_ready = ~r_buf_full;
  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;
  assign mode    = r_mode;
  assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an I2C controller model drives scl/sda, table of WRITE
// transactions plus hand-written READ, repeated-START and reset sequences.
module tb_i2c_target;
  import i2c_target_pkg::*;

  localparam int Q = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             scl;
  logic             tb_sda_low;
  wire              sda;
  logic             i_ready;
  logic             i_valid;
  logic [7:0]       i_data;
  logic             o_ready;
  logic             o_valid;
  logic [7:0]       o_data;
  i2c_transaction_t mode;
  logic             busy;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
    .i_ready (i_ready),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .mode    (mode),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Passive monitor: owns only its own counters and capture register.
  int         valid_cnt = 0;
  int         busy_cnt  = 0;
  int         low_cnt   = 0;
  logic [7:0] rx_data   = 8'h00;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (sda === 1'b0 && !tb_sda_low) low_cnt++;
    if (o_valid === 1'b1) begin
      valid_cnt++;
      rx_data = o_data;
    end
  end

  logic [7:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       ordy;
    logic       exp_aack;
    logic       exp_dack;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    tb_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    tb_sda_low = 1'b0;
    wait_clks(Q);
  endtask

  task automatic bit_cycle(input logic drive_low, output logic sampled);
    tb_sda_low = drive_low;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    sampled = sda;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic wr_byte(input string name, input logic [7:0] b, input logic exp_store,
                         output logic ack);
    logic s;
    int   v0;
    if (exp_store) exp_wr_q.push_back(b);
    v0 = valid_cnt;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, s);
    ack = ~s;
    if (valid_cnt != v0) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_valid: o_data 0x%0h with no byte pending", name, rx_data);
      end else begin
        check({name, "_o_data"}, rx_data, exp_wr_q.pop_front());
      end
    end
  endtask

  task automatic rd_byte(input string name, input logic ctrl_ack);
    logic [7:0] b;
    logic       s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b0, s);
      b[i] = s;
    end
    bit_cycle(ctrl_ack, s);
    if (exp_rd_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: read 0x%0h with no expected byte", name, b);
    end else begin
      check(name, b, exp_rd_q.pop_front());
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    wait_clks(1);
    i_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ack;
    logic s;
    int   v0, b0, l0;

    vecs[0] = '{addr: 7'h3C, data: 8'hA5, ordy: 1'b1, exp_aack: 1'b1, exp_dack: 1'b1};
    vecs[1] = '{addr: 7'h3D, data: 8'h77, ordy: 1'b1, exp_aack: 1'b0, exp_dack: 1'b0};
    vecs[2] = '{addr: 7'h3C, data: 8'h00, ordy: 1'b0, exp_aack: 1'b1, exp_dack: 1'b0};
    vecs[3] = '{addr: 7'h1E, data: 8'hC3, ordy: 1'b1, exp_aack: 1'b0, exp_dack: 1'b0};
    vecs[4] = '{addr: 7'h3C, data: 8'hFF, ordy: 1'b1, exp_aack: 1'b1, exp_dack: 1'b1};
    vecs[5] = '{addr: 7'h7C, data: 8'h5A, ordy: 1'b1, exp_aack: 1'b0, exp_dack: 1'b0};

    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    scl        = 1'b1;
    tb_sda_low = 1'b0;
    i_valid    = 1'b0;
    i_data     = 8'h00;
    o_ready    = 1'b0;
    wait_clks(4);
    check("rst_i_ready", i_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mode", mode, I2C_WRITE);
    check("rst_sda", sda, 1);
    rst = 1'b0;
    wait_clks(4);

    for (int k = 0; k < 6; k++) begin
      v0 = valid_cnt;
      b0 = busy_cnt;
      l0 = low_cnt;
      o_ready = vecs[k].ordy;
      i2c_start();
      wr_byte($sformatf("v%0d_addr", k), {vecs[k].addr, 1'b0}, 1'b0, ack);
      check($sformatf("v%0d_addr_ack", k), ack, vecs[k].exp_aack);
      wr_byte($sformatf("v%0d_d0", k), vecs[k].data, vecs[k].exp_dack, ack);
      check($sformatf("v%0d_d0_ack", k), ack, vecs[k].exp_dack);
      o_ready = 1'b1;
      wr_byte($sformatf("v%0d_d1", k), ~vecs[k].data, vecs[k].exp_dack, ack);
      check($sformatf("v%0d_d1_ack", k), ack, vecs[k].exp_dack);
      i2c_stop();
      wait_clks(Q);
      check($sformatf("v%0d_valid_pulses", k), valid_cnt - v0, vecs[k].exp_dack ? 2 : 0);
      check($sformatf("v%0d_busy_seen", k), busy_cnt != b0, vecs[k].exp_aack);
      check($sformatf("v%0d_sda_driven", k), low_cnt != l0, vecs[k].exp_aack);
      check($sformatf("v%0d_busy_after_stop", k), busy, 0);
    end
    check("wr_sb_empty", exp_wr_q.size(), 0);

    // READ: buffered byte first, then IDLE_BYTE once the buffer is drained.
    load_tx(8'h5A);
    check("rd_i_ready_full", i_ready, 0);
    i2c_start();
    wr_byte("rd_addr", 8'h79, 1'b0, ack);
    check("rd_addr_ack", ack, 1);
    check("rd_mode", mode, I2C_READ);
    check("rd_busy", busy, 1);
    check("rd_i_ready_after_load", i_ready, 1);
    exp_rd_q.push_back(8'h5A);
    rd_byte("rd_byte0", 1'b1);
    exp_rd_q.push_back(8'hFF);
    rd_byte("rd_byte1", 1'b0);
    check("rd_busy_after_nack", busy, 0);
    i2c_stop();
    wait_clks(Q);

    // Repeated START switches a WRITE-addressed transaction to READ.
    i2c_start();
    wr_byte("rs_addr_w", 8'h78, 1'b0, ack);
    check("rs_addr_w_ack", ack, 1);
    check("rs_mode_w", mode, I2C_WRITE);
    i2c_start();
    check("rs_busy_cleared", busy, 0);
    wr_byte("rs_addr_r", 8'h79, 1'b0, ack);
    check("rs_addr_r_ack", ack, 1);
    check("rs_mode_r", mode, I2C_READ);
    exp_rd_q.push_back(8'hFF);
    rd_byte("rs_byte", 1'b0);
    i2c_stop();
    wait_clks(Q);

    // Reset while the target is driving READ bit 3 low.
    load_tx(8'h00);
    i2c_start();
    wr_byte("mr_addr", 8'h79, 1'b0, ack);
    check("mr_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, s);
    check("mr_bit3_driven", sda, 0);
    rst = 1'b1;
    wait_clks(1);
    check("mr_sda_released", sda, 1);
    check("mr_busy_reset", busy, 0);
    rst = 1'b0;
    wait_clks(Q);
    o_ready = 1'b1;
    i2c_start();
    wr_byte("mr_waddr", 8'h78, 1'b0, ack);
    check("mr_waddr_ack", ack, 1);
    v0 = valid_cnt;
    wr_byte("mr_wdata", 8'h3C, 1'b1, ack);
    check("mr_wdata_ack", ack, 1);
    check("mr_valid_pulse", valid_cnt - v0, 1);
    check("mr_o_data_held", o_data, 8'h3C);
    i2c_stop();
    wait_clks(Q);
    check("final_wr_sb_empty", exp_wr_q.size(), 0);
    check("final_rd_sb_empty", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
